bf16_mul: RTL and testbench
===========================

// Module: bf16_mul
// PURPOSE
//  Single-cycle-registered BFloat16 multiplier: sign[15], exp[14:7] (bias 127), frac[6:0].
//  Multiplies flp_a*flp_b and exposes the intermediate datapath values (exponent sum,
//  unbiased exponent, normalized significand) for accuracy studies.
//  Sits as a leaf arithmetic unit in the floating-point datapath.
// PARAMETERS
//  None; format fixed to BF16 (constants in package, see STRUCTURE).
// PORTS
//  clk           in   1   rising-edge clock; the only clock
//  rst           in   1   synchronous, active-high reset
//  in_valid      in   1   flp_a/flp_b valid this cycle
//  flp_a         in   16  BF16 operand A
//  flp_b         in   16  BF16 operand B
//  out_valid     out  1   registered outputs hold the result of the last accepted pair
//  exponent      out  8   final biased result exponent after normalization/rounding
//  exp_unbiased  out  8   exp_sum - 127, modulo 256 (raw debug value)
//  exp_sum       out  9   ea + eb, zero-extended (raw debug value)
//  prod          out  8   normalized significand {hidden,frac[6:0]} of the result
//  sum           out  16  BF16 product
// BEHAVIOUR
//  - One cycle latency: sample on posedge when in_valid=1; outputs update next edge,
//    out_valid=1. in_valid=0 -> out_valid=0, data outputs hold. No backpressure.
//  - rst=1 at posedge: all outputs 0, out_valid 0; overrides a same-cycle in_valid.
//  - Sign = a[15]^b[15]. Significands sa={1,fa}, sb={1,fb}; p=sa*sb (16 bit).
//  - p[15]=1: prod=p[15:8], exponent=exp_sum-127+1, sticky from p[7:0].
//    else:    prod=p[14:7], exponent=exp_sum-127,   sticky from p[6:0].
//  - Default rounding: truncation (discarded bits dropped).
//  - Exponent evaluated in 10-bit signed: >=255 -> sum=+/-Inf (exp FF, frac 0);
//    <=0 -> sum=signed zero (no subnormal output).
//  - Specials (checked first; debug outputs still show raw computed values):
//    any exp==FF with frac!=0, or Inf*zero -> sum=16'h7FC0 (canonical NaN);
//    Inf*finite-nonzero -> signed Inf; any exp==00 (zero/subnormal, flushed) -> signed zero.
//  - Normal case: sum={sign, exponent, prod[6:0]}.
// CONFIGURATION
//  BF16_MUL_RNE_EN defined: round-to-nearest-even on discarded bits (guard/sticky, tie ->
//   even LSB); significand carry-out renormalizes (prod=8'h80, exponent+1), overflow to Inf.
//  Undefined: truncation as above.
// STRUCTURE
//  Package bf16_pkg: BIAS=127, EXP_MAX=8'hFF, QNAN=16'h7FC0, field widths, unpack typedef
//   {sign, exp[7:0], frac[6:0]}.
//  One sub-module: bf16_sig_mul (8x8 unsigned significand multiply + normalize + round).
// TESTING
//  1) a=16'hAAAA, b=16'hCCCC -> exp_sum=9'h0EE, exp_unbiased=8'h6F, prod=8'h87,
//     exponent=8'h70, sum=16'h3807.
//  2) a=16'h3F80, b=16'h3F80 -> exp_sum=9'h0FE, exp_unbiased=8'h7F, prod=8'h80, sum=16'h3F80.
//  3) a=16'h3FC1, b=16'h3FC1 -> sum=16'h4011 (truncate) / 16'h4012 (BF16_MUL_RNE_EN).
//  4) a=16'h7F00, b=16'h7F00 -> sum=16'h7F80; a=16'h0000, b=16'hC000 -> sum=16'h8000.
//  5) a=16'h7FC0 x any, and a=16'h7F80 x 16'h0000 -> sum=16'h7FC0.
//  6) rst=1 with in_valid=1 -> next cycle out_valid=0, all outputs 0; in_valid gaps hold data.

Source files
------------

// File: rtl/bf16_pkg.sv
// BF16 format constants, the unpacked operand view and field classifiers.
// Shared by bf16_mul and bf16_sig_mul.
package bf16_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 7;
   localparam int SIG_W  = FRAC_W + 1;
   localparam int PROD_W = 2 * SIG_W;

   localparam logic [EXP_W-1:0] BIAS    = 8'd127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [15:0]      QNAN    = 16'h7FC0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } bf16_t;

   function automatic logic is_nan(input bf16_t x);
      return (x.exp == EXP_MAX) && (x.frac != '0);
   endfunction

   function automatic logic is_inf(input bf16_t x);
      return (x.exp == EXP_MAX) && (x.frac == '0);
   endfunction

   // Subnormals are flushed, so any zero exponent reads as zero.
   function automatic logic is_zero(input bf16_t x);
      return x.exp == '0;
   endfunction

endpackage

// File: rtl/bf16_sig_mul.sv
// 8x8 significand multiply, normalize and round for bf16_mul.
// BF16_MUL_RNE_EN selects round-to-nearest-even; otherwise truncation.
module bf16_sig_mul
   import bf16_pkg::*;
(
   input  logic [FRAC_W-1:0] fa,
   input  logic [FRAC_W-1:0] fb,
   output logic [SIG_W-1:0]  prod,
   output logic [1:0]        adj
);

   logic [SIG_W-1:0]  sa;
   logic [SIG_W-1:0]  sb;
   logic [PROD_W-1:0] p;
   logic              hi;
   logic [SIG_W-1:0]  norm;

   assign sa   = {1'b1, fa};
   assign sb   = {1'b1, fb};
   assign p    = PROD_W'(sa) * PROD_W'(sb);
   assign hi   = p[PROD_W-1];
   assign norm = hi ? p[15:8] : p[14:7];

`ifdef BF16_MUL_RNE_EN
   logic       guard;
   logic       sticky;
   logic       rnd;
   logic [8:0] rsum;

   assign guard  = hi ? p[7] : p[6];
   assign sticky = hi ? |p[6:0] : |p[5:0];
   assign rnd    = guard & (sticky | norm[0]);
   assign rsum   = {1'b0, norm} + {8'd0, rnd};

   // A carry out of 1.1111111 lands exactly on 10.0000000.
   assign prod = rsum[8] ? 8'h80 : rsum[7:0];
   assign adj  = {1'b0, hi} + {1'b0, rsum[8]};
`else
   logic unused_bits;

   assign unused_bits = ^p[6:0];
   assign prod        = norm;
   assign adj         = {1'b0, hi};
`endif

endmodule

// File: rtl/bf16_mul.sv
// Registered BF16 multiplier with exposed exponent/significand debug values.
// Define BF16_MUL_RNE_EN for round-to-nearest-even (default truncation).
module bf16_mul
   import bf16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] flp_a,
   input  logic [15:0] flp_b,
   output logic        out_valid,
   output logic [7:0]  exponent,
   output logic [7:0]  exp_unbiased,
   output logic [8:0]  exp_sum,
   output logic [7:0]  prod,
   output logic [15:0] sum
);

   bf16_t              ua;
   bf16_t              ub;
   logic               sign;
   logic               nan_c;
   logic               inf_c;
   logic               zero_c;
   logic [8:0]         exp_sum_c;
   logic [7:0]         exp_unb_c;
   logic [7:0]         prod_c;
   logic [1:0]         adj;
   logic signed [9:0]  e_full;
   logic [15:0]        sum_c;

   assign ua   = flp_a;
   assign ub   = flp_b;
   assign sign = ua.sign ^ ub.sign;

   assign nan_c  = is_nan(ua) || is_nan(ub)
                 || (is_inf(ua) && is_zero(ub))
                 || (is_inf(ub) && is_zero(ua));
   assign inf_c  = is_inf(ua) || is_inf(ub);
   assign zero_c = is_zero(ua) || is_zero(ub);

   assign exp_sum_c = {1'b0, ua.exp} + {1'b0, ub.exp};
   assign exp_unb_c = exp_sum_c[7:0] - BIAS;

   bf16_sig_mul u_sig (
      .fa   (ua.frac),
      .fb   (ub.frac),
      .prod (prod_c),
      .adj  (adj)
   );

   // Wide signed view so overflow and underflow are both visible.
   assign e_full = $signed({1'b0, exp_sum_c})
                 - $signed({2'b00, BIAS})
                 + $signed({8'd0, adj});

   always_comb begin
      sum_c = {sign, e_full[7:0], prod_c[6:0]};
      if (nan_c)
         sum_c = QNAN;
      else if (inf_c)
         sum_c = {sign, EXP_MAX, 7'd0};
      else if (zero_c)
         sum_c = {sign, 15'd0};
      else if (e_full >= 10'sd255)
         sum_c = {sign, EXP_MAX, 7'd0};
      else if (e_full <= 10'sd0)
         sum_c = {sign, 15'd0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         exponent     <= '0;
         exp_unbiased <= '0;
         exp_sum      <= '0;
         prod         <= '0;
         sum          <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            exponent     <= e_full[7:0];
            exp_unbiased <= exp_unb_c;
            exp_sum      <= exp_sum_c;
            prod         <= prod_c;
            sum          <= sum_c;
         end
      end
   end

endmodule

// File: tb/tb_bf16_mul.sv
// Self-checking bench for bf16_mul: arithmetic reference model plus
// hand-computed literal vectors.
module tb_bf16_mul;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] flp_a;
   logic [15:0] flp_b;
   logic        out_valid;
   logic [7:0]  exponent;
   logic [7:0]  exp_unbiased;
   logic [8:0]  exp_sum;
   logic [7:0]  prod;
   logic [15:0] sum;

   int checks;
   int failures;
   bit chk_on;

   logic        m_valid;
   logic [7:0]  m_exponent;
   logic [7:0]  m_exp_unbiased;
   logic [8:0]  m_exp_sum;
   logic [7:0]  m_prod;
   logic [15:0] m_sum;

   bf16_mul dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .flp_a        (flp_a),
      .flp_b        (flp_b),
      .out_valid    (out_valid),
      .exponent     (exponent),
      .exp_unbiased (exp_unbiased),
      .exp_sum      (exp_sum),
      .prod         (prod),
      .sum          (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (a=%h b=%h)",
                  name, act, exp, flp_a, flp_b);
      end
   endtask

   // Reference: integer arithmetic on the real values' fields.
   task automatic model(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] s, output logic [7:0] e,
                        output logic [7:0] eu, output logic [8:0] es,
                        output logic [7:0] pr);
      int ea, eb, fa, fb, p, sh, m, rem, half, ex;
      bit sg, nan, inf, zero;
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      fa = int'(a[6:0]);
      fb = int'(b[6:0]);
      sg = a[15] ^ b[15];
      p  = (128 + fa) * (128 + fb);
      sh = (p >= 32768) ? 8 : 7;
      m  = p >> sh;
      rem  = p - (m << sh);
      half = 1 << (sh - 1);
`ifdef BF16_MUL_RNE_EN
      if (rem > half || (rem == half && (m % 2) == 1))
         m = m + 1;
`endif
      ex = ea + eb - 127 + (sh - 7);
      if (m == 256) begin
         m  = 128;
         ex = ex + 1;
      end
      es = 9'(ea + eb);
      eu = 8'((ea + eb - 127) & 255);
      e  = 8'(ex & 255);
      pr = 8'(m);
      nan  = (ea == 255 && fa != 0) || (eb == 255 && fb != 0)
           || (ea == 255 && eb == 0) || (eb == 255 && ea == 0);
      inf  = (ea == 255) || (eb == 255);
      zero = (ea == 0) || (eb == 0);
      if (nan)            s = 16'h7FC0;
      else if (inf)       s = {sg, 15'h7F80};
      else if (zero)      s = {sg, 15'h0000};
      else if (ex >= 255) s = {sg, 15'h7F80};
      else if (ex <= 0)   s = {sg, 15'h0000};
      else                s = {sg, 8'(ex), 7'(m % 128)};
   endtask

   always @(posedge clk) begin
      logic [15:0] s;
      logic [7:0]  e, eu, pr;
      logic [8:0]  es;
      if (rst) begin
         m_valid <= 1'b0;
         m_exponent <= '0;
         m_exp_unbiased <= '0;
         m_exp_sum <= '0;
         m_prod <= '0;
         m_sum <= '0;
      end else begin
         m_valid <= in_valid;
         if (in_valid) begin
            model(flp_a, flp_b, s, e, eu, es, pr);
            m_exponent <= e;
            m_exp_unbiased <= eu;
            m_exp_sum <= es;
            m_prod <= pr;
            m_sum <= s;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("out_valid", 16'(out_valid), 16'(m_valid));
         chk("sum", sum, m_sum);
         chk("exponent", 16'(exponent), 16'(m_exponent));
         chk("exp_unbiased", 16'(exp_unbiased), 16'(m_exp_unbiased));
         chk("exp_sum", 16'(exp_sum), 16'(m_exp_sum));
         chk("prod", 16'(prod), 16'(m_prod));
      end
   end

   // Called at a negedge; returns at the next negedge with outputs updated.
   task automatic drive(input logic v, input logic [15:0] a,
                        input logic [15:0] b);
      in_valid = v;
      flp_a    = a;
      flp_b    = b;
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      chk_on   = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      flp_a    = '0;
      flp_b    = '0;
      @(negedge clk);
      chk_on = 1'b1;
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_sum", sum, 16'h0000);
      rst = 1'b0;

      drive(1'b1, 16'hAAAA, 16'hCCCC);
      chk("t1_exp_sum", 16'(exp_sum), 16'h00EE);
      chk("t1_exp_unb", 16'(exp_unbiased), 16'h006F);
      chk("t1_prod", 16'(prod), 16'h0087);
      chk("t1_exponent", 16'(exponent), 16'h0070);
      chk("t1_sum", sum, 16'h3807);
      chk("t1_valid", 16'(out_valid), 16'd1);

      drive(1'b1, 16'h3F80, 16'h3F80);
      chk("t2_exp_sum", 16'(exp_sum), 16'h00FE);
      chk("t2_exp_unb", 16'(exp_unbiased), 16'h007F);
      chk("t2_prod", 16'(prod), 16'h0080);
      chk("t2_sum", sum, 16'h3F80);

      drive(1'b1, 16'h3FC1, 16'h3FC1);
`ifdef BF16_MUL_RNE_EN
      chk("t3_sum", sum, 16'h4012);
`else
      chk("t3_sum", sum, 16'h4011);
`endif

      drive(1'b1, 16'h7F00, 16'h7F00);
      chk("t4_ovf", sum, 16'h7F80);
      drive(1'b1, 16'h0000, 16'hC000);
      chk("t4_zero", sum, 16'h8000);

      drive(1'b0, 16'h1234, 16'h5678);
      chk("gap_valid", 16'(out_valid), 16'd0);
      chk("gap_hold", sum, 16'h8000);

      drive(1'b1, 16'h7FC0, 16'h3F80);
      chk("t5_nan", sum, 16'h7FC0);
      drive(1'b1, 16'h7F80, 16'h0000);
      chk("t5_inf0", sum, 16'h7FC0);
      drive(1'b1, 16'h7F80, 16'hC000);
      chk("inf_fin", sum, 16'hFF80);
      drive(1'b1, 16'h0080, 16'h0080);
      chk("uflow", sum, 16'h0000);
      drive(1'b1, 16'h4040, 16'h4040);
      chk("three_sq", sum, 16'h4110);
      drive(1'b1, 16'hC0A0, 16'h4000);
      chk("neg_ten", sum, 16'hC120);

      rst = 1'b1;
      drive(1'b1, 16'h3F80, 16'h4000);
      chk("t6_valid", 16'(out_valid), 16'd0);
      chk("t6_sum", sum, 16'h0000);
      chk("t6_prod", 16'(prod), 16'h0000);
      chk("t6_exp_sum", 16'(exp_sum), 16'h0000);
      rst = 1'b0;

      for (int i = 0; i < 64; i++)
         drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
               16'($urandom));

      drive(1'b0, 16'h0000, 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
